pipe_controller: RTL and testbench

PIPE_CONTROLLER -- requirements
Module: pipe_controller

---
 rtl/pipe_controller.sv | 202 ++++++++++++++++++++
 tb/tb_pipe_controller.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_controller.sv
// ---------------------------------------------------------------------------
// pipe_controller
//
// Control for a short in-order pipeline. It decodes the instruction held in
// the ID register into register-file read selects and ALU controls, and
// carries each destination register down a small pipeline to the writeback
// select. When an ID-stage source reads a register that an older, still
// in-flight instruction will write, it raises stall so that fetch holds its
// instruction. It also holds the ID register and injects a bubble.
//
// Parameters
//   WB_DEPTH   clock edges from ID capture to the writeback select (1..4)
//   HAZARD_EN  1: generate RAW stalls, 0: stall is tied low
//   ZERO_REG   1: register 0 is constant (never written, never a hazard)
//
// Ports
//   clk      rising-edge clock for all state
//   reset    synchronous, active-high reset
//   ibus     fetched instruction word
//   Aselect  one-hot rs read select (ID stage)
//   Bselect  one-hot rt read select (ID stage, R-type only)
//   Dselect  one-hot write select at the writeback stage
//   Imm      ID instruction is a legal I-type
//   S        ALU op: 000 XOR, 010 ADD, 011 SUB, 100 OR, 110 AND
//   Cin      ALU carry-in (set for SUB/SUBI)
//   stall    fetch must hold ibus for the next cycle
//   illegal  ID instruction cannot be decoded (handled as a bubble)
// ---------------------------------------------------------------------------
module pipe_controller #(
  parameter int WB_DEPTH  = 2,
  parameter int HAZARD_EN = 1,
  parameter int ZERO_REG  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ibus,
  output logic [31:0] Aselect,
  output logic [31:0] Bselect,
  output logic [31:0] Dselect,
  output logic        Imm,
  output logic [2:0]  S,
  output logic        Cin,
  output logic        stall,
  output logic        illegal
);

  typedef enum logic [1:0] {
    CLS_ILLEGAL,
    CLS_RTYPE,
    CLS_ITYPE
  } instr_cls_t;

  typedef enum logic [2:0] {
    ALU_XOR = 3'b000,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b011,
    ALU_OR  = 3'b100,
    ALU_AND = 3'b110
  } alu_op_t;

  function automatic logic [31:0] onehot(input logic [4:0] idx);
    onehot = 32'd1 << idx;
  endfunction

  // ID register and its fields
  logic [31:0] idex;
  logic [5:0]  op;
  logic [5:0]  func;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;

  assign op   = idex[31:26];
  assign rs   = idex[25:21];
  assign rt   = idex[20:16];
  assign rd   = idex[15:11];
  assign func = idex[5:0];

  // Shift-amount bits of the R-type encoding are not used by this datapath.
  logic unused_shamt;
  assign unused_shamt = ^idex[10:6];

  // -------------------------------------------------------------------------
  // Decode
  // -------------------------------------------------------------------------
  instr_cls_t cls;
  alu_op_t    alu_op;

  always_comb begin
    // NOTE: defaults first, so every path assigns every output and no latch
    // is inferred for the unlisted op/func codes.
    cls    = CLS_ILLEGAL;
    alu_op = ALU_XOR;
    if (op == 6'b000000) begin
      case (func)
        6'b000011: begin cls = CLS_RTYPE; alu_op = ALU_ADD; end
        6'b000010: begin cls = CLS_RTYPE; alu_op = ALU_SUB; end
        6'b000001: begin cls = CLS_RTYPE; alu_op = ALU_XOR; end
        6'b000111: begin cls = CLS_RTYPE; alu_op = ALU_AND; end
        6'b000100: begin cls = CLS_RTYPE; alu_op = ALU_OR;  end
        default:   begin cls = CLS_ILLEGAL; alu_op = ALU_XOR; end
      endcase
    end else begin
      case (op)
        6'b000011: begin cls = CLS_ITYPE; alu_op = ALU_ADD; end
        6'b000010: begin cls = CLS_ITYPE; alu_op = ALU_SUB; end
        6'b000001: begin cls = CLS_ITYPE; alu_op = ALU_XOR; end
        6'b001111: begin cls = CLS_ITYPE; alu_op = ALU_AND; end
        6'b001100: begin cls = CLS_ITYPE; alu_op = ALU_OR;  end
        default:   begin cls = CLS_ILLEGAL; alu_op = ALU_XOR; end
      endcase
    end
  end

  logic rtype;
  logic itype;
  logic legal;

  assign rtype = (cls == CLS_RTYPE);
  assign itype = (cls == CLS_ITYPE);
  assign legal = rtype || itype;

  assign Aselect = onehot(rs);
  // The all-zero word is the reset bubble; it keeps its rt decode (register 0)
  // so both read ports idle on r0 after reset. Any other illegal word and
  // every I-type leave port B deselected.
  assign Bselect = (rtype || idex == 32'd0) ? onehot(rt) : 32'd0;
  assign Imm     = itype;
  assign S       = alu_op;
  assign Cin     = S[1] & S[0];
  assign illegal = !legal;

  // Destination of the ID instruction and whether it really writes.
  logic [4:0] id_dest;
  logic       id_valid;

  assign id_dest  = rtype ? rd : rt;
  assign id_valid = legal && ((id_dest != 5'd0) || (ZERO_REG == 0));

  // -------------------------------------------------------------------------
  // Destination pipeline: entry 0 follows ID, entry WB_DEPTH-1 is writeback.
  // -------------------------------------------------------------------------
  logic [WB_DEPTH-1:0] pipe_valid;
  logic [4:0]          pipe_dest [WB_DEPTH];

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for all state, so every register samples
    // the pre-edge values and the shift does not collapse.
    if (reset) begin
      idex       <= 32'd0;
      pipe_valid <= '0;
    end else begin
      if (!stall) begin
        idex <= ibus;
      end
      // A stalled ID instruction must not enter the pipeline yet: bubble.
      pipe_valid[0] <= id_valid && !stall;
      for (int k = 1; k < WB_DEPTH; k++) begin
        pipe_valid[k] <= pipe_valid[k-1];
      end
    end
  end

  // NOTE: the destination fields carry no reset; the valid bits alone decide
  // whether an entry means anything, so stale register numbers are harmless.
  always_ff @(posedge clk) begin
    pipe_dest[0] <= id_dest;
    for (int k = 1; k < WB_DEPTH; k++) begin
      pipe_dest[k] <= pipe_dest[k-1];
    end
  end

  assign Dselect = pipe_valid[WB_DEPTH-1] ? onehot(pipe_dest[WB_DEPTH-1]) : 32'd0;

  // -------------------------------------------------------------------------
  // RAW hazard. The last entry writes during the current cycle, so a read of
  // that register in ID already sees the new value and is not a hazard.
  // -------------------------------------------------------------------------
  logic rs_live;
  logic rt_live;
  logic hazard;

  assign rs_live = !((ZERO_REG != 0) && (rs == 5'd0));
  assign rt_live = !((ZERO_REG != 0) && (rt == 5'd0));

  always_comb begin
    hazard = 1'b0;
    for (int k = 0; k < WB_DEPTH - 1; k++) begin
      if (legal && pipe_valid[k]) begin
        if (rs_live && (rs == pipe_dest[k])) begin
          hazard = 1'b1;
        end
        if (rtype && rt_live && (rt == pipe_dest[k])) begin
          hazard = 1'b1;
        end
      end
    end
  end

  assign stall = (HAZARD_EN != 0) && hazard;

endmodule

// File: tb/tb_pipe_controller.sv
// ---------------------------------------------------------------------------
// tb_pipe_controller
//
// Four controller instances share clk and reset:
//   a: WB_DEPTH=2 (defaults)    b: WB_DEPTH=3
//   c: WB_DEPTH=3, HAZARD_EN=0  d: WB_DEPTH=1
// Each instance has its own ibus. When an instruction is offered, the bench
// decodes it with its own model and pushes the expected Dselect onto that
// instance's queue. A negedge monitor pops the queue whenever Dselect is
// non-zero. Directed checks cover decode, timing, stalls and reset.
// ---------------------------------------------------------------------------
module tb_pipe_controller;

  localparam logic [5:0] F_ADD = 6'b000011;
  localparam logic [5:0] F_SUB = 6'b000010;
  localparam logic [5:0] F_XOR = 6'b000001;
  localparam logic [5:0] F_AND = 6'b000111;
  localparam logic [5:0] F_OR  = 6'b000100;
  localparam logic [5:0] O_ADDI = 6'b000011;
  localparam logic [5:0] O_XORI = 6'b000001;
  localparam logic [5:0] O_ANDI = 6'b001111;
  localparam logic [5:0] O_ORI  = 6'b001100;

  logic clk = 1'b0;
  logic reset;

  logic [31:0] a_ibus, a_asel, a_bsel, a_dsel;
  logic [31:0] b_ibus, b_asel, b_bsel, b_dsel;
  logic [31:0] c_ibus, c_asel, c_bsel, c_dsel;
  logic [31:0] d_ibus, d_asel, d_bsel, d_dsel;
  logic [2:0]  a_s, b_s, c_s, d_s;
  logic        a_imm, a_cin, a_stall, a_ill;
  logic        b_imm, b_cin, b_stall, b_ill;
  logic        c_imm, c_cin, c_stall, c_ill;
  logic        d_imm, d_cin, d_stall, d_ill;

  always #5 clk = ~clk;

  pipe_controller #(.WB_DEPTH(2), .HAZARD_EN(1), .ZERO_REG(1)) u_dut_a (
    .clk(clk), .reset(reset), .ibus(a_ibus), .Aselect(a_asel), .Bselect(a_bsel),
    .Dselect(a_dsel), .Imm(a_imm), .S(a_s), .Cin(a_cin), .stall(a_stall), .illegal(a_ill));

  pipe_controller #(.WB_DEPTH(3), .HAZARD_EN(1), .ZERO_REG(1)) u_dut_b (
    .clk(clk), .reset(reset), .ibus(b_ibus), .Aselect(b_asel), .Bselect(b_bsel),
    .Dselect(b_dsel), .Imm(b_imm), .S(b_s), .Cin(b_cin), .stall(b_stall), .illegal(b_ill));

  pipe_controller #(.WB_DEPTH(3), .HAZARD_EN(0), .ZERO_REG(1)) u_dut_c (
    .clk(clk), .reset(reset), .ibus(c_ibus), .Aselect(c_asel), .Bselect(c_bsel),
    .Dselect(c_dsel), .Imm(c_imm), .S(c_s), .Cin(c_cin), .stall(c_stall), .illegal(c_ill));

  pipe_controller #(.WB_DEPTH(1), .HAZARD_EN(1), .ZERO_REG(1)) u_dut_d (
    .clk(clk), .reset(reset), .ibus(d_ibus), .Aselect(d_asel), .Bselect(d_bsel),
    .Dselect(d_dsel), .Imm(d_imm), .S(d_s), .Cin(d_cin), .stall(d_stall), .illegal(d_ill));

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] q_a [$];
  logic [31:0] q_b [$];
  logic [31:0] q_c [$];
  logic [31:0] q_d [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Encoders
  function automatic logic [31:0] r_op(input logic [5:0] fn, input logic [4:0] rd,
                                       input logic [4:0] rs, input logic [4:0] rt);
    return {6'b000000, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] i_op(input logic [5:0] opc, input logic [4:0] rt,
                                       input logic [4:0] rs, input logic [15:0] imm);
    return {opc, rs, rt, imm};
  endfunction

  // Reference model: does this word write a register, and which select.
  function automatic logic writes(input logic [31:0] w, output logic [31:0] sel);
    logic [5:0] opc;
    logic [5:0] fn;
    logic       lgl;
    logic [4:0] dst;
    opc = w[31:26];
    fn  = w[5:0];
    if (opc == 6'd0) begin
      lgl = fn inside {F_ADD, F_SUB, F_XOR, F_AND, F_OR};
      dst = w[15:11];
    end else begin
      lgl = opc inside {O_ADDI, 6'b000010, O_XORI, O_ANDI, O_ORI};
      dst = w[20:16];
    end
    sel = 32'd1 << dst;
    return lgl && (dst != 5'd0);
  endfunction

  function automatic logic stall_of(input int which);
    case (which)
      0:       return a_stall;
      1:       return b_stall;
      2:       return c_stall;
      default: return d_stall;
    endcase
  endfunction

  task automatic drive(input int which, input logic [31:0] w);
    case (which)
      0:       a_ibus = w;
      1:       b_ibus = w;
      2:       c_ibus = w;
      default: d_ibus = w;
    endcase
  endtask

  task automatic push(input int which, input logic [31:0] sel);
    case (which)
      0:       q_a.push_back(sel);
      1:       q_b.push_back(sel);
      2:       q_c.push_back(sel);
      default: q_d.push_back(sel);
    endcase
  endtask

  // Offer one instruction at a negedge, hold it while the DUT stalls, and
  // return 1 ns after the capturing edge with ibus back at idle (0).
  task automatic issue(input int which, input logic [31:0] w, output int stalls);
    int n;
    logic [31:0] sel;
    n = 0;
    @(negedge clk);
    drive(which, w);
    if (writes(w, sel)) push(which, sel);
    while (stall_of(which) === 1'b1 && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (n >= 8) check("issue_stall_bound", n, 0);
    @(posedge clk);
    #1;
    drive(which, 32'd0);
    stalls = n;
  endtask

  // Scoreboard monitors
  always @(negedge clk) begin
    if (a_dsel !== 32'd0) begin
      if (q_a.size() == 0) check("a_sb_spurious", a_dsel, 32'd0);
      else                 check("a_sb_write", a_dsel, q_a.pop_front());
    end
  end
  always @(negedge clk) begin
    if (b_dsel !== 32'd0) begin
      if (q_b.size() == 0) check("b_sb_spurious", b_dsel, 32'd0);
      else                 check("b_sb_write", b_dsel, q_b.pop_front());
    end
  end
  always @(negedge clk) begin
    if (c_dsel !== 32'd0) begin
      if (q_c.size() == 0) check("c_sb_spurious", c_dsel, 32'd0);
      else                 check("c_sb_write", c_dsel, q_c.pop_front());
    end
  end
  always @(negedge clk) begin
    if (d_dsel !== 32'd0) begin
      if (q_d.size() == 0) check("d_sb_spurious", d_dsel, 32'd0);
      else                 check("d_sb_write", d_dsel, q_d.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [31:0] tbl_instr [8];
  logic [2:0]  tbl_s     [8];
  logic        tbl_imm   [8];
  int          nst;

  initial begin
    tbl_instr[0] = r_op(F_XOR, 5'd20, 5'd1, 5'd2);              tbl_s[0] = 3'b000; tbl_imm[0] = 1'b0;
    tbl_instr[1] = r_op(F_AND, 5'd21, 5'd1, 5'd2);              tbl_s[1] = 3'b110; tbl_imm[1] = 1'b0;
    tbl_instr[2] = r_op(F_OR,  5'd22, 5'd1, 5'd2);              tbl_s[2] = 3'b100; tbl_imm[2] = 1'b0;
    tbl_instr[3] = r_op(F_SUB, 5'd23, 5'd1, 5'd2);              tbl_s[3] = 3'b011; tbl_imm[3] = 1'b0;
    tbl_instr[4] = i_op(O_ADDI, 5'd24, 5'd1, 16'h0005);         tbl_s[4] = 3'b010; tbl_imm[4] = 1'b1;
    tbl_instr[5] = i_op(O_XORI, 5'd25, 5'd1, 16'h00F0);         tbl_s[5] = 3'b000; tbl_imm[5] = 1'b1;
    tbl_instr[6] = i_op(O_ANDI, 5'd26, 5'd1, 16'h0F0F);         tbl_s[6] = 3'b110; tbl_imm[6] = 1'b1;
    tbl_instr[7] = i_op(O_ORI,  5'd27, 5'd1, 16'h8001);         tbl_s[7] = 3'b100; tbl_imm[7] = 1'b1;

    // Reset, with a real instruction on ibus that must be discarded.
    reset  = 1'b1;
    a_ibus = 32'h02374003;
    b_ibus = 32'd0;
    c_ibus = 32'd0;
    d_ibus = 32'd0;
    @(negedge clk);
    reset  = 1'b0;
    a_ibus = 32'd0;
    check("rst_aselect", a_asel, 32'h0000_0001);
    check("rst_bselect", a_bsel, 32'h0000_0001);
    check("rst_dselect", a_dsel, 32'd0);
    check("rst_imm",     a_imm, 1'b0);
    check("rst_s",       a_s, 3'b000);
    check("rst_cin",     a_cin, 1'b0);
    check("rst_stall",   a_stall, 1'b0);
    check("rst_illegal", a_ill, 1'b1);
    check("rst_b_illegal", b_ill, 1'b1);

    // ADD r8 = r17 + r23 on WB_DEPTH=2
    issue(0, 32'h02374003, nst);
    check("add_stall_cnt", nst, 0);
    @(negedge clk);
    check("add_aselect", a_asel, 32'd1 << 17);
    check("add_bselect", a_bsel, 32'd1 << 23);
    check("add_s",       a_s, 3'b010);
    check("add_cin",     a_cin, 1'b0);
    check("add_imm",     a_imm, 1'b0);
    check("add_illegal", a_ill, 1'b0);
    check("add_dsel_e0", a_dsel, 32'd0);
    @(negedge clk);
    check("add_dsel_e1", a_dsel, 32'd0);
    @(negedge clk);
    check("add_dsel_e2", a_dsel, 32'd1 << 8);

    // SUBI r31 = r17 - imm
    issue(0, 32'h0A3FFFF1, nst);
    @(negedge clk);
    check("subi_imm",     a_imm, 1'b1);
    check("subi_s",       a_s, 3'b011);
    check("subi_cin",     a_cin, 1'b1);
    check("subi_bselect", a_bsel, 32'd0);
    check("subi_aselect", a_asel, 32'd1 << 17);
    @(negedge clk);
    check("subi_dsel_e1", a_dsel, 32'd0);
    @(negedge clk);
    check("subi_dsel_e2", a_dsel, 32'd1 << 31);

    // Decode table
    for (int i = 0; i < 8; i++) begin
      issue(0, tbl_instr[i], nst);
      check("tbl_stall_cnt", nst, 0);
      @(negedge clk);
      check("tbl_s",       a_s, tbl_s[i]);
      check("tbl_imm",     a_imm, tbl_imm[i]);
      check("tbl_cin",     a_cin, tbl_s[i][1] & tbl_s[i][0]);
      check("tbl_illegal", a_ill, 1'b0);
    end

    // RAW on rs, WB_DEPTH=2: one stall cycle for the next fetch
    issue(0, r_op(F_ADD, 5'd8, 5'd17, 5'd23), nst);
    issue(0, r_op(F_OR,  5'd9, 5'd8,  5'd2),  nst);
    issue(0, r_op(F_XOR, 5'd4, 5'd1,  5'd2),  nst);
    check("a_rs_hazard_stalls", nst, 1);

    // RAW on rt of an R-type
    issue(0, r_op(F_ADD, 5'd8,  5'd17, 5'd23), nst);
    issue(0, r_op(F_AND, 5'd10, 5'd3,  5'd8),  nst);
    issue(0, r_op(F_XOR, 5'd4,  5'd1,  5'd2),  nst);
    check("a_rt_hazard_stalls", nst, 1);

    // rt of an I-type is a destination, not a source: no hazard
    issue(0, r_op(F_ADD, 5'd8, 5'd17, 5'd23), nst);
    issue(0, i_op(O_ORI, 5'd8, 5'd1, 16'h0003), nst);
    issue(0, r_op(F_XOR, 5'd4, 5'd1, 5'd2), nst);
    check("a_itype_rt_no_hazard", nst, 0);

    // An instruction reading its own destination does not stall itself
    issue(0, r_op(F_ADD, 5'd5, 5'd5, 5'd5), nst);
    issue(0, r_op(F_XOR, 5'd4, 5'd1, 5'd2), nst);
    check("a_self_no_hazard", nst, 0);

    // ADDI to r0, then a read of r0
    issue(0, i_op(O_ADDI, 5'd0, 5'd1, 16'h0005), nst);
    issue(0, r_op(F_ADD, 5'd9, 5'd0, 5'd0), nst);
    check("r0_read_stall_cnt", nst, 0);
    @(negedge clk);
    check("r0_read_stall", a_stall, 1'b0);
    @(negedge clk);
    check("r0_wb_slot_dsel", a_dsel, 32'd0);
    @(negedge clk);
    check("r0_reader_dsel", a_dsel, 32'd1 << 9);

    // Illegal words never stall, never write
    issue(0, r_op(F_ADD, 5'd9, 5'd1, 5'd2), nst);
    issue(0, {6'b111111, 5'd9, 5'd9, 16'h4800}, nst);
    @(negedge clk);
    check("ill_op_illegal", a_ill, 1'b1);
    check("ill_op_s",       a_s, 3'b000);
    check("ill_op_imm",     a_imm, 1'b0);
    check("ill_op_cin",     a_cin, 1'b0);
    check("ill_op_bselect", a_bsel, 32'd0);
    check("ill_op_stall",   a_stall, 1'b0);
    issue(0, r_op(6'b000101, 5'd7, 5'd9, 5'd9), nst);
    @(negedge clk);
    check("ill_func_illegal", a_ill, 1'b1);
    check("ill_func_stall",   a_stall, 1'b0);

    // WB_DEPTH=3: ADD r8 then OR reading r8 -> two stall cycles, OR held
    issue(1, r_op(F_ADD, 5'd8, 5'd17, 5'd23), nst);
    issue(1, r_op(F_OR,  5'd9, 5'd8,  5'd2),  nst);
    @(negedge clk);
    check("b_stall_c1",   b_stall, 1'b1);
    check("b_hold_c1",    b_asel, 32'd1 << 8);
    check("b_dsel_c1",    b_dsel, 32'd0);
    @(negedge clk);
    check("b_stall_c2",   b_stall, 1'b1);
    check("b_hold_c2",    b_asel, 32'd1 << 8);
    @(negedge clk);
    check("b_stall_c3",   b_stall, 1'b0);
    check("b_add_wb",     b_dsel, 32'd1 << 8);
    issue(1, r_op(F_XOR, 5'd4, 5'd1, 5'd2), nst);
    check("b_after_stall_cnt", nst, 0);

    // Same sequence with HAZARD_EN=0: one per cycle, no stall
    issue(2, r_op(F_ADD, 5'd8, 5'd17, 5'd23), nst);
    issue(2, r_op(F_OR,  5'd9, 5'd8,  5'd2),  nst);
    issue(2, r_op(F_XOR, 5'd4, 5'd1,  5'd2),  nst);
    check("c_no_stall_cnt", nst, 0);
    @(negedge clk);
    check("c_stall_low", c_stall, 1'b0);

    // WB_DEPTH=1: no hazard window at all
    issue(3, r_op(F_ADD, 5'd8, 5'd17, 5'd23), nst);
    issue(3, r_op(F_OR,  5'd9, 5'd8,  5'd2),  nst);
    check("d_or_stall_cnt", nst, 0);
    @(negedge clk);
    check("d_add_wb_one_edge", d_dsel, 32'd1 << 8);
    check("d_stall_low", d_stall, 1'b0);

    // Let everything drain
    repeat (8) @(negedge clk);
    check("drain_a", q_a.size(), 0);
    check("drain_b", q_b.size(), 0);
    check("drain_c", q_c.size(), 0);
    check("drain_d", q_d.size(), 0);

    // Reset in the middle of a stall on WB_DEPTH=3
    issue(1, r_op(F_ADD, 5'd8, 5'd17, 5'd23), nst);
    issue(1, r_op(F_OR,  5'd9, 5'd8,  5'd2),  nst);
    @(negedge clk);
    check("b_pre_rst_stall", b_stall, 1'b1);
    reset  = 1'b1;
    b_ibus = r_op(F_ADD, 5'd12, 5'd3, 5'd4);
    q_b.delete();
    @(negedge clk);
    reset  = 1'b0;
    b_ibus = 32'd0;
    check("b_rst_stall",   b_stall, 1'b0);
    check("b_rst_dsel",    b_dsel, 32'd0);
    check("b_rst_illegal", b_ill, 1'b1);
    check("b_rst_aselect", b_asel, 32'h0000_0001);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("b_rst_no_wb", b_dsel, 32'd0);
    end
    repeat (4) @(negedge clk);
    check("drain_b_final", q_b.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
